// File: rtl/pkt_cnt_pkg.sv
// pkt_cnt_pkg
// Shared types and default sizes for the packet counter slice.
//   step_e : decoded step request applied to the main counter
//   load_e : which load (if any) wins in the current cycle
//   DEF_WIDTH / DEF_EVT_WIDTH : default counter widths
package pkt_cnt_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_EVT_WIDTH = 4;

  typedef enum logic [1:0] {
    HOLD,
    UP,
    DOWN
  } step_e;

  typedef enum logic [2:0] {
    NONE,
    L0,
    L1,
    LMAX,
    LVAL
  } load_e;

endpackage

// File: rtl/pkt_cnt_step.sv
// pkt_cnt_step
// Combinational next-value and bound detection for the main counter.
// Ports:
//   count      in  WIDTH  current counter value
//   step       in  step_e requested step (HOLD/UP/DOWN)
//   next_count out WIDTH  counter value after the step
//   ovf_hit    out 1      up-step requested at the all-ones value
//   udf_hit    out 1      down-step requested at zero
// SATURATE=0 wraps at the bounds, SATURATE=1 holds at the bounds.
module pkt_cnt_step
  import pkt_cnt_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  step_e            step,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_hit,
  output logic             udf_hit
);

  localparam logic [WIDTH-1:0] MAX_V = '1;

  always_comb begin
    next_count = count;
    ovf_hit    = 1'b0;
    udf_hit    = 1'b0;
    case (step)
      UP: begin
        if (count == MAX_V) begin
          ovf_hit    = 1'b1;
          next_count = (SATURATE != 0) ? MAX_V : '0;
        end else begin
          next_count = count + WIDTH'(1);
        end
      end
      DOWN: begin
        if (count == '0) begin
          udf_hit    = 1'b1;
          next_count = (SATURATE != 0) ? '0 : MAX_V;
        end else begin
          next_count = count - WIDTH'(1);
        end
      end
      default: next_count = count;
    endcase
  end

endmodule

// File: rtl/pkt_cnt_gen.sv
// pkt_cnt_gen
// Up/down counter with prioritised loads, wrap/saturate bounds, an
// independent event counter, registered zero/max flags and sticky
// overflow/underflow flags.
// Ports:
//   clk, reset (synchronous, active low)
//   en                    : increment event counter
//   en_up / en_down       : step main counter (both or neither = hold)
//   load0/load1/loadmax/load_val, load_data : loads, load0 highest
//   clr_flags             : clear sticky ovf/udf
//   snap                  : capture snapshot
//   count, count_evt      : counter values
//   at_zero, at_max       : registered flags aligned with count
//   ovf, udf              : sticky bound flags
//   snap_count, snap_evt  : captured values
// Optional feature macro: PKT_CNT_SNAPSHOT_EN builds the snapshot
// registers; without it snap is ignored and the snapshot outputs read 0.
module pkt_cnt_gen
  import pkt_cnt_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EVT_WIDTH = DEF_EVT_WIDTH,
  parameter int LOAD_MAX  = 255,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 en_up,
  input  logic                 en_down,
  input  logic                 load0,
  input  logic                 load1,
  input  logic                 loadmax,
  input  logic                 load_val,
  input  logic [WIDTH-1:0]     load_data,
  input  logic                 clr_flags,
  input  logic                 snap,
  output logic [WIDTH-1:0]     count,
  output logic [EVT_WIDTH-1:0] count_evt,
  output logic                 at_zero,
  output logic                 at_max,
  output logic                 ovf,
  output logic                 udf,
  output logic [WIDTH-1:0]     snap_count,
  output logic [EVT_WIDTH-1:0] snap_evt
);

  localparam logic [WIDTH-1:0] LOAD_MAX_V = WIDTH'(LOAD_MAX);
  localparam logic [WIDTH-1:0] MAX_V      = '1;

  load_e            load_sel;
  step_e            step_sel;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] count_next;
  logic             ovf_hit;
  logic             udf_hit;

  // Resolve the winning load; any load suppresses stepping so that
  // loads can never raise a bound flag.
  always_comb begin
    load_sel = NONE;
    if (load0)         load_sel = L0;
    else if (load1)    load_sel = L1;
    else if (loadmax)  load_sel = LMAX;
    else if (load_val) load_sel = LVAL;

    step_sel = HOLD;
    if (load_sel == NONE) begin
      if (en_up && !en_down)      step_sel = UP;
      else if (en_down && !en_up) step_sel = DOWN;
    end
  end

  pkt_cnt_step #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_step (
    .count     (count),
    .step      (step_sel),
    .next_count(step_next),
    .ovf_hit   (ovf_hit),
    .udf_hit   (udf_hit)
  );

  always_comb begin
    case (load_sel)
      L0:      count_next = '0;
      L1:      count_next = WIDTH'(1);
      LMAX:    count_next = LOAD_MAX_V;
      LVAL:    count_next = load_data;
      default: count_next = step_next;
    endcase
  end

  // Flags are derived from count_next so they change on the same edge as
  // count; a new bound hit overrides a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      count_evt <= '0;
      at_zero   <= 1'b1;
      at_max    <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      count     <= count_next;
      if (en) count_evt <= count_evt + EVT_WIDTH'(1);
      at_zero   <= (count_next == '0);
      at_max    <= (count_next == MAX_V);
      ovf       <= ovf_hit | (ovf & ~clr_flags);
      udf       <= udf_hit | (udf & ~clr_flags);
    end
  end

`ifdef PKT_CNT_SNAPSHOT_EN
  // Snapshot captures the values visible during the snap cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_count <= '0;
      snap_evt   <= '0;
    end else if (snap) begin
      snap_count <= count;
      snap_evt   <= count_evt;
    end
  end
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign snap_count  = '0;
  assign snap_evt    = '0;
`endif

endmodule

// File: tb/tb_pkt_cnt_gen.sv
// tb_pkt_cnt_gen
// Drives one wrapping and one saturating pkt_cnt_gen with shared stimulus.
// Expected values are queued per cycle and a monitor compares them
// shortly after each rising edge.
module tb_pkt_cnt_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, en_up, en_down, load0, load1, loadmax, load_val;
  logic [7:0] load_data;
  logic       clr_flags, snap;

  logic [7:0] w_count, s_count, w_snap_count, s_snap_count;
  logic [3:0] w_evt, s_evt, w_snap_evt, s_snap_evt;
  logic       w_az, w_am, w_ovf, w_udf, s_az, s_am, s_ovf, s_udf;

`ifdef PKT_CNT_SNAPSHOT_EN
  localparam bit SNAP_ON = 1'b1;
`else
  localparam bit SNAP_ON = 1'b0;
`endif

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] count;
    logic [3:0] evt;
    logic       az;
    logic       am;
    logic       ov;
    logic       ud;
    logic [7:0] sc;
    logic [3:0] se;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  pkt_cnt_gen #(.WIDTH(8), .EVT_WIDTH(4), .LOAD_MAX(255), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .en_up(en_up), .en_down(en_down),
    .load0(load0), .load1(load1), .loadmax(loadmax), .load_val(load_val),
    .load_data(load_data), .clr_flags(clr_flags), .snap(snap),
    .count(w_count), .count_evt(w_evt), .at_zero(w_az), .at_max(w_am),
    .ovf(w_ovf), .udf(w_udf), .snap_count(w_snap_count), .snap_evt(w_snap_evt)
  );

  pkt_cnt_gen #(.WIDTH(8), .EVT_WIDTH(4), .LOAD_MAX(255), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .en_up(en_up), .en_down(en_down),
    .load0(load0), .load1(load1), .loadmax(loadmax), .load_val(load_val),
    .load_data(load_data), .clr_flags(clr_flags), .snap(snap),
    .count(s_count), .count_evt(s_evt), .at_zero(s_az), .at_max(s_am),
    .ovf(s_ovf), .udf(s_udf), .snap_count(s_snap_count), .snap_evt(s_snap_evt)
  );

  // Monitor: pops every expectation queued for the edge just taken.
  always @(posedge clk) begin
    exp_t       e;
    logic [7:0] a_count, a_sc;
    logic [3:0] a_evt, a_se;
    logic       a_az, a_am, a_ov, a_ud;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        a_count = w_count; a_evt = w_evt; a_az = w_az; a_am = w_am;
        a_ov = w_ovf; a_ud = w_udf; a_sc = w_snap_count; a_se = w_snap_evt;
      end else begin
        a_count = s_count; a_evt = s_evt; a_az = s_az; a_am = s_am;
        a_ov = s_ovf; a_ud = s_udf; a_sc = s_snap_count; a_se = s_snap_evt;
      end
      tests_run++;
      if (a_count !== e.count || a_evt !== e.evt || a_az !== e.az || a_am !== e.am ||
          a_ov !== e.ov || a_ud !== e.ud || a_sc !== e.sc || a_se !== e.se) begin
        tests_failed++;
        $display("[TB] FAIL %s dut%0d: got count=%h evt=%h az=%b am=%b ovf=%b udf=%b sc=%h se=%h, want count=%h evt=%h az=%b am=%b ovf=%b udf=%b sc=%h se=%h",
                 e.name, e.dut, a_count, a_evt, a_az, a_am, a_ov, a_ud, a_sc, a_se,
                 e.count, e.evt, e.az, e.am, e.ov, e.ud, e.sc, e.se);
      end
    end
  end

  // Queue the expected outputs of one DUT for the coming rising edge.
  task automatic checkOutput(input string name, input int dut, input logic [7:0] c,
                             input logic [3:0] ev, input logic az, input logic am,
                             input logic ov, input logic ud, input logic [7:0] sc,
                             input logic [3:0] se);
    exp_t e;
    e.name = name; e.dut = dut; e.count = c; e.evt = ev; e.az = az; e.am = am;
    e.ov = ov; e.ud = ud; e.sc = sc; e.se = se;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs (called at a falling edge) and clock it.
  task automatic applyStimulus(input logic rst_n, input logic e_en, input logic up,
                               input logic dn, input logic l0, input logic l1,
                               input logic lm, input logic lv, input logic [7:0] d,
                               input logic clr, input logic snp);
    reset = rst_n; en = e_en; en_up = up; en_down = dn;
    load0 = l0; load1 = l1; loadmax = lm; load_val = lv; load_data = d;
    clr_flags = clr; snap = snp;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] sc7;
    logic [3:0] se1;
    sc7 = SNAP_ON ? 8'd7 : 8'd0;
    se1 = SNAP_ON ? 4'd1 : 4'd0;
    reset = 1'b0; en = 1'b0; en_up = 1'b0; en_down = 1'b0; load0 = 1'b0;
    load1 = 1'b0; loadmax = 1'b0; load_val = 1'b0; load_data = 8'h00;
    clr_flags = 1'b0; snap = 1'b0;
    @(negedge clk);

    // Reset held with every strobe asserted.
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_w", 0, 8'h00, 4'd0, 1, 0, 0, 0, 8'h00, 4'd0);
      checkOutput("reset_s", 1, 8'h00, 4'd0, 1, 0, 0, 0, 8'h00, 4'd0);
      applyStimulus(0, 1, 1, 1, 1, 1, 1, 1, 8'h5A, 1, 1);
    end

    checkOutput("release", 0, 8'h01, 4'd1, 0, 0, 0, 0, 8'h00, 4'd0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0);

    // Load priority.
    checkOutput("prio_l1_w", 0, 8'h01, 4'd1, 0, 0, 0, 0, 8'h00, 4'd0);
    checkOutput("prio_l1_s", 1, 8'h01, 4'd1, 0, 0, 0, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 1, 0, 0, 1, 1, 1, 8'h5A, 0, 0);
    checkOutput("prio_lmax", 0, 8'hFF, 4'd1, 0, 1, 0, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 1, 8'h5A, 0, 0);
    checkOutput("prio_lval", 0, 8'h5A, 4'd1, 0, 0, 0, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 8'h5A, 0, 0);

    // Upper bound.
    checkOutput("loadmax_s", 1, 8'hFF, 4'd1, 0, 1, 0, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    checkOutput("wrap_up", 0, 8'h00, 4'd1, 1, 0, 1, 0, 8'h00, 4'd0);
    checkOutput("sat_up1", 1, 8'hFF, 4'd1, 0, 1, 1, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    checkOutput("wrap_up2", 0, 8'h01, 4'd1, 0, 0, 1, 0, 8'h00, 4'd0);
    checkOutput("sat_up2", 1, 8'hFF, 4'd1, 0, 1, 1, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    checkOutput("sat_up3", 1, 8'hFF, 4'd1, 0, 1, 1, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0);

    // Lower bound.
    checkOutput("load0_w", 0, 8'h00, 4'd1, 1, 0, 1, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    checkOutput("wrap_down", 0, 8'hFF, 4'd1, 0, 1, 1, 1, 8'h00, 4'd0);
    checkOutput("sat_down", 1, 8'h00, 4'd1, 1, 0, 1, 1, 8'h00, 4'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0);

    // Flag clearing and set-wins-over-clear.
    checkOutput("clr_w", 0, 8'hFF, 4'd1, 0, 1, 0, 0, 8'h00, 4'd0);
    checkOutput("clr_s", 1, 8'h00, 4'd1, 1, 0, 0, 0, 8'h00, 4'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0);
    checkOutput("clr_dn_w", 0, 8'hFE, 4'd1, 0, 0, 0, 0, 8'h00, 4'd0);
    checkOutput("clr_dn_s", 1, 8'h00, 4'd1, 1, 0, 0, 1, 8'h00, 4'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 1, 0);
    checkOutput("both_hold_w", 0, 8'hFE, 4'd1, 0, 0, 0, 0, 8'h00, 4'd0);
    checkOutput("both_hold_s", 1, 8'h00, 4'd1, 1, 0, 0, 1, 8'h00, 4'd0);
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0);

    // Event counter runs while load0 is held: 1 + 16 wraps back to 1.
    for (int i = 0; i < 15; i++) applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    checkOutput("evt_16", 0, 8'h00, 4'd1, 1, 0, 0, 0, 8'h00, 4'd0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    checkOutput("evt_17_w", 0, 8'h00, 4'd2, 1, 0, 0, 0, 8'h00, 4'd0);
    checkOutput("evt_17_s", 1, 8'h00, 4'd2, 1, 0, 0, 1, 8'h00, 4'd0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);

    // Reset mid-operation overrides strobes.
    checkOutput("mid_reset", 1, 8'h00, 4'd0, 1, 0, 0, 0, 8'h00, 4'd0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 1);

    // Snapshot.
    checkOutput("snap_setup", 0, 8'h07, 4'd1, 0, 0, 0, 0, 8'h00, 4'd0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 8'h07, 0, 0);
    checkOutput("snap_take", 0, 8'h08, 4'd2, 0, 0, 0, 0, sc7, se1);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 1);
    checkOutput("snap_hold", 0, 8'h08, 4'd2, 0, 0, 0, 0, sc7, se1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    checkOutput("snap_again", 1, 8'h07, 4'd2, 0, 0, 0, 0,
                SNAP_ON ? 8'h08 : 8'h00, SNAP_ON ? 4'd2 : 4'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 1);

    // Drain: every queued expectation must have been consumed.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pkt_cnt_gen.md
Name: pkt_cnt_gen

Overview:
Parametrised successor to the packet detector's byte/event counter. It provides a WIDTH-bit up/down counter with prioritised loads (zero, one, max, arbitrary value) and a selectable wrap or saturate mode. It also has an independent EVT_WIDTH-bit event counter and registered status flags (zero, max, sticky overflow/underflow). It sits beside the packet detector FSM, which drives load and step strobes per received byte.

Parameters:
WIDTH, 8, bit width of main counter count
EVT_WIDTH, 4, bit width of event counter count_evt
LOAD_MAX, 255, value loaded by loadmax; must be <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at bounds; 1 = hold at bounds (0 and 2**WIDTH-1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
en  in  1  increment event counter
en_up  in  1  increment main counter
en_down  in  1  decrement main counter
load0  in  1  load main counter with 0
load1  in  1  load main counter with 1
loadmax  in  1  load main counter with LOAD_MAX
load_val  in  1  load main counter with load_data
load_data  in  WIDTH  value for load_val
clr_flags  in  1  clear ovf/udf sticky flags
snap  in  1  capture snapshot (optional feature)
count  out  WIDTH  main counter value
count_evt  out  EVT_WIDTH  event counter value
at_zero  out  1  count == 0
at_max  out  1  count == 2**WIDTH-1
ovf  out  1  sticky: up-step attempted at 2**WIDTH-1
udf  out  1  sticky: down-step attempted at 0
snap_count  out  WIDTH  captured count
snap_evt  out  EVT_WIDTH  captured count_evt

Behaviour:
- All state updates on posedge clk. Reset is sampled only on the edge: reset==0 forces count=0, count_evt=0, ovf=0, udf=0, snap_count=0, snap_evt=0, at_zero=1, at_max=0. Reset mid-operation overrides every strobe in that cycle.
- Main counter priority, highest first: load0 > load1 > loadmax > load_val > step. Only the highest asserted load takes effect.
- Step, applied only when no load is asserted:
  - en_up only: +1.
  - en_down only: -1.
  - Both or neither: hold.
- Event counter is independent of main-counter loads and steps. en increments it in the same cycle as any main-counter action. It always wraps modulo 2**EVT_WIDTH and is cleared only by reset.
- Upper bound: up-step at 2**WIDTH-1 sets ovf. Result: SATURATE=0 → 0; SATURATE=1 → 2**WIDTH-1.
- Lower bound: down-step at 0 sets udf. Result: SATURATE=0 → 2**WIDTH-1; SATURATE=1 → 0.
- Loads never set ovf or udf.
- ovf/udf are sticky until reset or clr_flags.
  - clr_flags in the same cycle as a new bound event: the set wins (flag = 1).
- at_zero and at_max are registered and computed from the next-state count, so they are valid in the same cycle count updates. There is zero-cycle skew between count and its flags; the latency from strobe to count/flags is 1 clock.
- Arithmetic is unsigned, modulo 2**WIDTH. load_data is taken as-is.

Optional Feature:
PKT_CNT_SNAPSHOT_EN
- Defined: on snap=1, snap_count and snap_evt register the pre-update count and count_evt (the values visible in the snap cycle). They hold otherwise and clear on reset.
- Undefined: snap is ignored, no snapshot flops are built, and snap_count/snap_evt are tied to 0. The port list is identical in both builds.

Decomposition:
- Package pkt_cnt_pkg:
  - Step-decode enum: HOLD, UP, DOWN.
  - Load-select enum: NONE, L0, L1, LMAX, LVAL.
  - Default width constants.
- One natural sub-module: pkt_cnt_step, the combinational next-value/bound-detect unit for WIDTH/SATURATE. It returns next count, ovf_hit and udf_hit, and is instantiated once in pkt_cnt_gen.

Test Plan:
- Reset: hold reset=0 with all strobes high for 2 cycles → count=0, count_evt=0, at_zero=1, ovf=udf=0; release → next edge follows strobes.
- Load priority: load1=loadmax=load_val=1, load_data=8'h5A → count=1; drop load1 → 255, at_max=1; drop loadmax → 8'h5A.
- Wrap (SATURATE=0): count=255, en_up → count=0, ovf=1, at_zero=1; en_down → 255, udf=1; clr_flags → ovf=udf=0.
- Saturate (SATURATE=1): count=255, 3x en_up → stays 255, ovf=1; count=0, en_down → 0, udf=1; en_up+en_down together → hold.
- Event independence: en pulsed 17 times with EVT_WIDTH=4 while load0 held → count_evt=1, count=0.
- Snapshot (macro defined): count=7, snap+en_up same cycle → snap_count=7, count=8; macro undefined → snap_count stays 0.
